// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: state encoding for elastic stages and hazard blocks.
package pipe_pkg;

  localparam int unsigned STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_EMPTY = 2'b00;
  localparam state_t ST_BUSY  = 2'b01;
  localparam state_t ST_FULL  = 2'b10;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffer pipeline stage with registered ready; all outputs decode from state/main.
// Optional synchronous flush port enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic            flush_i,
`endif
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [size-1:0] data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [size-1:0] data_o,
  output logic [1:0]      occ_o
);

  state_t          state, state_nxt;
  logic [size-1:0] main_q, main_nxt;
  logic [size-1:0] skid_q, skid_nxt;
  logic            fire_in, fire_out;

  // State and data registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  assign fire_in  = valid_i & ready_o;
  assign fire_out = valid_o & ready_i;

  // Next-state and data-path selection
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state)
      ST_EMPTY: begin
        if (fire_in) begin
          state_nxt = ST_BUSY;
          main_nxt  = data_i;
        end
      end
      ST_BUSY: begin
        if (fire_in && !fire_out) begin
          state_nxt = ST_FULL;
          skid_nxt  = data_i;
        end else if (!fire_in && fire_out) begin
          state_nxt = ST_EMPTY;
        end else if (fire_in && fire_out) begin
          main_nxt  = data_i;
        end
      end
      ST_FULL: begin
        if (fire_out) begin
          state_nxt = ST_BUSY;
          main_nxt  = skid_q;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
`ifdef PIPE_SKID_FLUSH_EN
    if (flush_i) begin
      state_nxt = ST_EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end
`endif
  end

  // Output decode from registered state only
  always_comb begin
    occ_o = 2'd0;
    case (state)
      ST_BUSY: occ_o = 2'd1;
      ST_FULL: occ_o = 2'd2;
      default: occ_o = 2'd0;
    endcase
  end

  assign ready_o = (state != ST_FULL);
  assign valid_o = (state != ST_EMPTY);
  assign data_o  = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and scoreboard bench for pipe_skid_reg; covers flush when PIPE_SKID_FLUSH_EN is defined.
module tb_pipe_skid_reg;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [1:0]  occ_o;

  int n_cmp;
  int n_err;

  pipe_skid_reg #(.size(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
`ifdef PIPE_SKID_FLUSH_EN
    .flush_i (flush_i),
`endif
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .occ_o   (occ_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i   = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b1;
    ready_i = 1'b0;
    data_i  = 32'hDEADBEEF;
    step();
    n_cmp++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b exp 0", valid_o); end
    n_cmp++;
    if (data_o !== 32'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", data_o); end
    n_cmp++;
    if (occ_o !== 2'd0) begin n_err++; $display("FAIL reset_occ got %0d exp 0", occ_o); end
    n_cmp++;
    if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b exp 1", ready_o); end
    rst_i = 1'b1;
    step();
    valid_i = 1'b0;
    n_cmp++;
    if (data_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL first_word_data got %h exp deadbeef", data_o); end
    n_cmp++;
    if (valid_o !== 1'b1 || occ_o !== 2'd1) begin
      n_err++; $display("FAIL first_word_valid got v=%0b occ=%0d exp v=1 occ=1", valid_o, occ_o);
    end
  endtask

  task automatic test_streaming();
    ready_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      data_i = 32'(i);
      step();
      n_cmp++;
      if (data_o !== 32'(i) || valid_o !== 1'b1) begin
        n_err++; $display("FAIL stream_data[%0d] got %h v=%0b exp %h v=1", i, data_o, valid_o, 32'(i));
      end
      n_cmp++;
      if (occ_o !== 2'd1 || ready_o !== 1'b1) begin
        n_err++; $display("FAIL stream_occ[%0d] got occ=%0d rdy=%0b exp occ=1 rdy=1", i, occ_o, ready_o);
      end
    end
    valid_i = 1'b0;
    step();
    n_cmp++;
    if (occ_o !== 2'd0 || valid_o !== 1'b0) begin
      n_err++; $display("FAIL stream_drain got occ=%0d v=%0b exp occ=0 v=0", occ_o, valid_o);
    end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 32'd5;
    step();
    ready_i = 1'b0;
    data_i  = 32'd6;
    step();
    n_cmp++;
    if (occ_o !== 2'd2 || ready_o !== 1'b0 || data_o !== 32'd5) begin
      n_err++; $display("FAIL bp_full got occ=%0d rdy=%0b d=%0d exp occ=2 rdy=0 d=5", occ_o, ready_o, data_o);
    end
    data_i = 32'd7;
    step();
    n_cmp++;
    if (occ_o !== 2'd2 || data_o !== 32'd5 || valid_o !== 1'b1) begin
      n_err++; $display("FAIL bp_hold got occ=%0d d=%0d v=%0b exp occ=2 d=5 v=1", occ_o, data_o, valid_o);
    end
    ready_i = 1'b1;
    step();
    n_cmp++;
    if (data_o !== 32'd6 || occ_o !== 2'd1 || ready_o !== 1'b1) begin
      n_err++; $display("FAIL bp_release got d=%0d occ=%0d rdy=%0b exp d=6 occ=1 rdy=1", data_o, occ_o, ready_o);
    end
    step();
    valid_i = 1'b0;
    n_cmp++;
    if (data_o !== 32'd7 || occ_o !== 2'd1) begin
      n_err++; $display("FAIL bp_accept7 got d=%0d occ=%0d exp d=7 occ=1", data_o, occ_o);
    end
    step();
    n_cmp++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL bp_drain got v=%0b exp 0", valid_o); end
  endtask

  task automatic test_random_stress();
    logic [31:0] q[$];
    logic [31:0] seq;
    logic [31:0] held;
    logic        hold_chk;
    logic        m_in, m_out;
    seq = 32'h100;
    for (int c = 0; c < 1000; c++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 2) != 0);
      data_i  = seq;
      m_in  = valid_i && (q.size() < 2);
      m_out = (q.size() != 0) && ready_i;
      if (q.size() != 0) begin
        n_cmp++;
        if (data_o !== q[0]) begin n_err++; $display("FAIL stress_head c=%0d got %h exp %h", c, data_o, q[0]); end
      end
      hold_chk = valid_o && !ready_i;
      held     = data_o;
      step();
      if (m_out) void'(q.pop_front());
      if (m_in) begin
        q.push_back(seq);
        seq = seq + 32'd1;
      end
      n_cmp++;
      if (occ_o !== 2'(q.size()) || valid_o !== (q.size() != 0) || ready_o !== (q.size() < 2)) begin
        n_err++;
        $display("FAIL stress_status c=%0d got occ=%0d v=%0b rdy=%0b exp occ=%0d", c, occ_o, valid_o, ready_o, q.size());
      end
      if (hold_chk) begin
        n_cmp++;
        if (data_o !== held || valid_o !== 1'b1) begin
          n_err++; $display("FAIL stress_stable c=%0d got %h v=%0b exp %h v=1", c, data_o, valid_o, held);
        end
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    while (q.size() != 0) begin
      n_cmp++;
      if (data_o !== q[0] || valid_o !== 1'b1) begin
        n_err++; $display("FAIL stress_drain got %h v=%0b exp %h v=1", data_o, valid_o, q[0]);
      end
      step();
      void'(q.pop_front());
    end
    n_cmp++;
    if (occ_o !== 2'd0) begin n_err++; $display("FAIL stress_empty got occ=%0d exp 0", occ_o); end
  endtask

  task automatic test_async_reset_full();
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 32'hA;
    step();
    data_i  = 32'hB;
    step();
    valid_i = 1'b0;
    n_cmp++;
    if (occ_o !== 2'd2) begin n_err++; $display("FAIL areset_prefill got occ=%0d exp 2", occ_o); end
    #2;
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if (valid_o !== 1'b0 || occ_o !== 2'd0 || ready_o !== 1'b1 || data_o !== 32'h0) begin
      n_err++;
      $display("FAIL areset_outputs got v=%0b occ=%0d rdy=%0b d=%h exp v=0 occ=0 rdy=1 d=0", valid_o, occ_o, ready_o, data_o);
    end
    step();
    rst_i = 1'b1;
    ready_i = 1'b1;
    step();
    n_cmp++;
    if (valid_o !== 1'b0 || occ_o !== 2'd0) begin
      n_err++; $display("FAIL areset_discard got v=%0b occ=%0d exp v=0 occ=0", valid_o, occ_o);
    end
  endtask

`ifdef PIPE_SKID_FLUSH_EN
  task automatic test_flush();
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 32'h11;
    step();
    data_i  = 32'h22;
    step();
    n_cmp++;
    if (occ_o !== 2'd2) begin n_err++; $display("FAIL flush_prefill got occ=%0d exp 2", occ_o); end
    flush_i = 1'b1;
    ready_i = 1'b1;
    data_i  = 32'h33;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0 || occ_o !== 2'd0 || ready_o !== 1'b1 || data_o !== 32'h0) begin
      n_err++;
      $display("FAIL flush_state got v=%0b occ=%0d rdy=%0b d=%h exp v=0 occ=0 rdy=1 d=0", valid_o, occ_o, ready_o, data_o);
    end
    step();
    n_cmp++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush_no_emit got v=%0b exp 0", valid_o); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_random_stress();
    test_async_reset_full();
`ifdef PIPE_SKID_FLUSH_EN
    test_flush();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
